// File: rtl/multi_key_debounce.sv
// N-channel key debouncer: 2-flop synchroniser, shared sample tick and a
// per-channel stability filter producing a clean level plus press/release/hold pulses.
module multi_key_debounce #(
    parameter int N          = 4,
    parameter int TICK_DIV   = 25,
    parameter int STABLE_CNT = 3,
    parameter int HOLD_TICKS = 100,
    parameter int ACTIVE_LOW = 1
) (
    input  logic         clk,
    input  logic         nCR,
    input  logic [N-1:0] button,
    output logic [N-1:0] level,
    output logic [N-1:0] press_pulse,
    output logic [N-1:0] release_pulse,
    output logic [N-1:0] hold_pulse,
    output logic         tick
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (STABLE_CNT > 0) ? $clog2(STABLE_CNT + 1) : 1;
    localparam int HW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CNT - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
    localparam logic          PRESSED   = (ACTIVE_LOW == 0);
    localparam logic [N-1:0]  IDLE      = (ACTIVE_LOW != 0) ? {N{1'b1}} : {N{1'b0}};

    logic [TW-1:0] r_tick_cnt;
    logic [N-1:0]  r_meta;
    logic [N-1:0]  r_sync;
    logic          w_tick;

    assign w_tick = (r_tick_cnt == TICK_LAST);
    assign tick   = w_tick;

    always_ff @(posedge clk or negedge nCR) begin
        if (!nCR) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nCR) begin
        if (!nCR) begin
            r_meta <= IDLE;
            r_sync <= IDLE;
        end else begin
            r_meta <= button;
            r_sync <= r_meta;
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_ch
        logic [SW-1:0] r_stab;
        logic [HW-1:0] r_hold_cnt;
        logic          r_level;
        logic          r_hold_done;
        logic          r_press;
        logic          r_release;
        logic          r_hold;
        logic          w_accept;

        // New value has now been seen on STABLE_CNT consecutive ticks
        assign w_accept = (r_sync[gi] != r_level) && (r_stab == STAB_LAST);

        always_ff @(posedge clk or negedge nCR) begin
            if (!nCR) begin
                r_stab      <= '0;
                r_hold_cnt  <= '0;
                r_level     <= ~PRESSED;
                r_hold_done <= 1'b0;
                r_press     <= 1'b0;
                r_release   <= 1'b0;
                r_hold      <= 1'b0;
            end else begin
                r_press   <= 1'b0;
                r_release <= 1'b0;
                r_hold    <= 1'b0;
                if (w_tick) begin
                    if (r_sync[gi] == r_level) begin
                        r_stab <= '0;
                    end else if (w_accept) begin
                        r_stab  <= '0;
                        r_level <= r_sync[gi];
                    end else begin
                        r_stab <= r_stab + 1'b1;
                    end

                    if (w_accept && (r_sync[gi] == PRESSED)) begin
                        r_press <= 1'b1;
                    end

                    // Hold timer only runs while the accepted level is pressed
                    if (r_level == PRESSED) begin
                        if (w_accept) begin
                            r_release   <= 1'b1;
                            r_hold_cnt  <= '0;
                            r_hold_done <= 1'b0;
                        end else if (!r_hold_done) begin
                            r_hold_cnt <= r_hold_cnt + 1'b1;
                            if (r_hold_cnt == HOLD_LAST) begin
                                r_hold      <= 1'b1;
                                r_hold_done <= 1'b1;
                            end
                        end
                    end
                end
            end
        end

        assign level[gi]         = r_level;
        assign press_pulse[gi]   = r_press;
        assign release_pulse[gi] = r_release;
        assign hold_pulse[gi]    = r_hold;
    end

endmodule

// File: tb/tb_multi_key_debounce.sv
// Scoreboard bench for multi_key_debounce: per-cycle expected outputs from a
// sample-history reference model, compared by an independent negedge monitor.
module tb_multi_key_debounce;

    localparam int TD = 4;
    localparam int SC = 3;
    localparam int HT = 5;

    logic       clk;
    logic       nCR;
    logic [1:0] button;
    logic [1:0] level;
    logic [1:0] press_pulse;
    logic [1:0] release_pulse;
    logic [1:0] hold_pulse;
    logic       tick;

    multi_key_debounce #(
        .N(2), .TICK_DIV(TD), .STABLE_CNT(SC), .HOLD_TICKS(HT), .ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .nCR(nCR), .button(button), .level(level),
        .press_pulse(press_pulse), .release_pulse(release_pulse),
        .hold_pulse(hold_pulse), .tick(tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Expected output word: {tick, level, press, release, hold}
    logic [8:0] sbq[$];

    // Reference model state
    int         m_e;
    logic [1:0] raw_hist[$];
    logic [1:0] tsmp[$];
    logic [1:0] m_level;
    int         m_chg[2];
    int         m_held[2];

    // Monitor-side observations of the DUT
    int mcyc = 0;
    int n_press[2];
    int n_rel[2];
    int n_hold[2];
    int press_cyc[2];
    int hold_cyc[2];
    logic [8:0] mon_exp;
    logic [8:0] mon_act;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_e = 0;
        raw_hist.delete();
        tsmp.delete();
        m_level = 2'b11;
        for (int c = 0; c < 2; c++) begin
            m_chg[c]  = -1;
            m_held[c] = 0;
        end
    endtask

    // A level flips once the last SC tick samples taken since its previous
    // change all disagree with it; hold fires on the HT-th tick spent pressed.
    task automatic model_step(input logic rst_ok, input logic [1:0] b);
        logic [1:0] prs, rel, hld, smp;
        logic       flip;
        int         t;
        prs = 2'b00; rel = 2'b00; hld = 2'b00;
        if (!rst_ok) begin
            model_reset();
            sbq.push_back({1'b0, 2'b11, 6'b0});
            return;
        end
        m_e++;
        if ((m_e - 1) % TD == TD - 1) begin
            smp = (m_e >= 3) ? raw_hist[m_e - 3] : 2'b11;
            tsmp.push_back(smp);
            t = tsmp.size() - 1;
            for (int c = 0; c < 2; c++) begin
                flip = 1'b0;
                if (t - m_chg[c] >= SC) begin
                    flip = 1'b1;
                    for (int k = 0; k < SC; k++)
                        if (tsmp[t - k][c] == m_level[c]) flip = 1'b0;
                end
                if (flip) begin
                    m_level[c] = ~m_level[c];
                    m_chg[c] = t;
                    if (m_level[c] == 1'b0) prs[c] = 1'b1;
                    else begin
                        rel[c] = 1'b1;
                        m_held[c] = 0;
                    end
                end else if (m_level[c] == 1'b0) begin
                    m_held[c]++;
                    if (m_held[c] == HT) hld[c] = 1'b1;
                end
            end
        end
        raw_hist.push_back(b);
        sbq.push_back({(m_e % TD == TD - 1), m_level, prs, rel, hld});
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            model_step(nCR, button);
            #1;
        end
    endtask

    task automatic wait_level(input string nm, input logic [1:0] mask,
                              input logic [1:0] val, input int bound);
        int k;
        k = 0;
        while (((level & mask) !== val) && (k < bound)) begin
            step(1);
            k++;
        end
        chk(nm, int'(level & mask), int'(val));
    endtask

    always @(negedge clk) begin
        mcyc++;
        if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_empty: no expected entry at cycle %0d", mcyc);
        end else begin
            mon_exp = sbq.pop_front();
            mon_act = {tick, level, press_pulse, release_pulse, hold_pulse};
            checks++;
            if (mon_act !== mon_exp) begin
                failures++;
                $display("FAIL sb cyc=%0d got tick/lvl/prs/rel/hld=%b/%b/%b/%b/%b expected %b/%b/%b/%b/%b",
                         mcyc, mon_act[8], mon_act[7:6], mon_act[5:4], mon_act[3:2], mon_act[1:0],
                         mon_exp[8], mon_exp[7:6], mon_exp[5:4], mon_exp[3:2], mon_exp[1:0]);
            end
        end
        for (int c = 0; c < 2; c++) begin
            if (press_pulse[c] === 1'b1) begin n_press[c]++; press_cyc[c] = mcyc; end
            if (release_pulse[c] === 1'b1) n_rel[c]++;
            if (hold_pulse[c] === 1'b1) begin n_hold[c]++; hold_cyc[c] = mcyc; end
        end
    end

    initial begin
        int p0, r0, h0, p1, r1, nt;
        for (int c = 0; c < 2; c++) begin
            n_press[c] = 0; n_rel[c] = 0; n_hold[c] = 0;
            press_cyc[c] = 0; hold_cyc[c] = 0;
        end
        model_reset();
        nCR    = 1'b0;
        button = 2'b11;
        step(3);
        @(negedge clk); #1;
        nCR = 1'b1;

        // Idle after reset, ticks on edges 3, 7, 11
        nt = 0;
        for (int k = 1; k <= 12; k++) begin
            step(1);
            if (tick) begin
                nt++;
                chk("tick_phase", k % TD, TD - 1);
            end
        end
        chk("tick_count", nt, 3);
        chk("idle_level", int'(level), 3);

        // Short glitches must never be accepted
        p0 = n_press[0]; r0 = n_rel[0];
        for (int g = 0; g < 10; g++) begin
            button[0] = 1'b0; step(2 * TD);
            button[0] = 1'b1; step(2 * TD);
        end
        step(16);
        chk("glitch_level", int'(level[0]), 1);
        chk("glitch_press", n_press[0] - p0, 0);
        chk("glitch_rel", n_rel[0] - r0, 0);

        // Press, long hold, release, press again
        p0 = n_press[0]; h0 = n_hold[0]; r0 = n_rel[0]; p1 = n_press[1];
        button[0] = 1'b0;
        wait_level("press0_lat", 2'b01, 2'b00, 14);
        step(HT * TD + 8);
        chk("press0_once", n_press[0] - p0, 1);
        chk("ch1_untouched", n_press[1] - p1, 0);
        chk("hold0_once", n_hold[0] - h0, 1);
        chk("hold0_delay", hold_cyc[0] - press_cyc[0], HT * TD);
        step(40);
        chk("hold0_norepeat", n_hold[0] - h0, 1);
        button[0] = 1'b1;
        wait_level("rel0_lat", 2'b01, 2'b01, 14);
        step(2);
        chk("rel0_once", n_rel[0] - r0, 1);
        button[0] = 1'b0;
        wait_level("repress0_lat", 2'b01, 2'b00, 14);
        step(HT * TD + 8);
        chk("hold0_again", n_hold[0] - h0, 2);
        chk("hold0_again_delay", hold_cyc[0] - press_cyc[0], HT * TD);
        button[0] = 1'b1;
        step(20);

        // Both channels pressed on the same cycle
        p0 = n_press[0]; p1 = n_press[1];
        button = 2'b00;
        wait_level("both_lat", 2'b11, 2'b00, 14);
        step(2);
        chk("both_press0", n_press[0] - p0, 1);
        chk("both_press1", n_press[1] - p1, 1);
        chk("both_same_cyc", press_cyc[0], press_cyc[1]);

        // Reset while channel 1 is held
        button = 2'b01;
        wait_level("ch0_rel_lat", 2'b01, 2'b01, 14);
        step(4);
        r1 = n_rel[1]; p1 = n_press[1];
        @(negedge clk); #1;
        nCR = 1'b0;
        #1;
        chk("rst_level", int'(level), 3);
        chk("rst_no_rel", int'(release_pulse), 0);
        step(2);
        @(negedge clk); #1;
        nCR = 1'b1;
        wait_level("requal1_lat", 2'b10, 2'b00, 14);
        step(2);
        chk("requal1_press", n_press[1] - p1, 1);
        chk("requal1_no_rel", n_rel[1] - r1, 0);

        // Randomised key activity
        for (int r = 0; r < 150; r++) begin
            button = 2'($urandom_range(0, 3));
            step($urandom_range(1, 24));
        end
        button = 2'b11;
        step(30);
        chk("final_idle", int'(level), 3);

        @(negedge clk); #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
